// File: rtl/rv32i_pc_gen_pkg.sv
// Shared types and constants for the RV32IM fetch PC generator.
package rv32i_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } pc_state_e;

  localparam int unsigned PC_INC   = 32'd4;
  // Widest PC the pending buffer can hold; narrower PCs are zero-extended.
  localparam int unsigned PC_MAX_W = 32'd32;

  typedef struct packed {
    logic                valid;
    logic                is_trap;
    logic [PC_MAX_W-1:0] target;
  } pc_pend_t;

  function automatic logic is_word_aligned(input logic [1:0] lsb);
    is_word_aligned = (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/rv32i_pc_gen_if.sv
// Fetch-side bus of the PC generator: control in from EX/MEM/WB, PC out to IMEM and IF/ID.
interface rv32i_pc_gen_if #(
  parameter int WIDTH = 32
);
  logic             i_stall;
  logic             i_redirect;
  logic [WIDTH-1:0] i_redirect_target;
  logic             i_trap;
  logic [WIDTH-1:0] o_pc;
  logic [WIDTH-1:0] o_pc_plus4;
  logic             o_valid;
  logic             o_flush;
  logic             o_misalign;
  logic [WIDTH-1:0] o_bad_addr;

  modport slave (
    input  i_stall, i_redirect, i_redirect_target, i_trap,
    output o_pc, o_pc_plus4, o_valid, o_flush, o_misalign, o_bad_addr
  );

  modport master (
    output i_stall, i_redirect, i_redirect_target, i_trap,
    input  o_pc, o_pc_plus4, o_valid, o_flush, o_misalign, o_bad_addr
  );
endinterface

// File: rtl/rv32i_pc_gen_next_sel.sv
// Next-PC priority mux with redirect-target alignment handling.
// Misaligned targets trap only when RV32I_PC_MISALIGN_EN is defined; otherwise bits [1:0] are cleared.
module rv32i_pc_next_sel
  import rv32i_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] TRAP_VECTOR = WIDTH'(32'h0000_0100)
) (
  input  logic [WIDTH-1:0] i_pc,
  input  logic             i_trap,
  input  logic             i_redirect,
  input  logic [WIDTH-1:0] i_redirect_target,
  input  pc_pend_t         i_pend,
  output logic [WIDTH-1:0] o_next_pc,
  output logic             o_flush,
  output logic             o_misalign,
  output logic [WIDTH-1:0] o_bad_addr
);

  logic [WIDTH-1:0] w_seq_pc;
  logic [WIDTH-1:0] w_pri_pc;
  logic             w_pri_flush;
  logic             w_use_tgt;
  logic [WIDTH-1:0] w_tgt;

  assign w_seq_pc = i_pc + WIDTH'(PC_INC);

  // Fixed-priority source select: live trap, live redirect, pending trap, pending target, sequential.
  always_comb begin
    w_pri_pc    = w_seq_pc;
    w_pri_flush = 1'b0;
    w_use_tgt   = 1'b0;
    w_tgt       = '0;
    if (i_trap) begin
      w_pri_pc    = TRAP_VECTOR;
      w_pri_flush = 1'b1;
    end else if (i_redirect) begin
      w_use_tgt = 1'b1;
      w_tgt     = i_redirect_target;
    end else if (i_pend.valid && i_pend.is_trap) begin
      w_pri_pc    = TRAP_VECTOR;
      w_pri_flush = 1'b1;
    end else if (i_pend.valid) begin
      w_use_tgt = 1'b1;
      w_tgt     = i_pend.target[WIDTH-1:0];
    end else begin
      w_pri_pc = w_seq_pc;
    end
  end

  // Resolve a selected redirect target into the final next PC.
  always_comb begin
    o_next_pc  = w_pri_pc;
    o_flush    = w_pri_flush;
    o_misalign = 1'b0;
    o_bad_addr = '0;
    if (w_use_tgt) begin
      o_flush = 1'b1;
`ifdef RV32I_PC_MISALIGN_EN
      if (!is_word_aligned(w_tgt[1:0])) begin
        o_next_pc  = TRAP_VECTOR;
        o_misalign = 1'b1;
        o_bad_addr = w_tgt;
      end else begin
        o_next_pc = w_tgt;
      end
`else
      o_next_pc = w_tgt & ~WIDTH'(32'd3);
`endif
    end else begin
      o_next_pc = w_pri_pc;
    end
  end

endmodule

// File: rtl/rv32i_pc_gen.sv
// Fetch program-counter generator: BOOT/RUN/PEND FSM, PC register and stall-safe redirect buffer.
// Optional misaligned-target trapping is enabled by defining RV32I_PC_MISALIGN_EN.
module rv32i_pc_gen
  import rv32i_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(32'h0000_0100)
) (
  input  logic                clk,
  input  logic                rst,
  rv32i_pc_gen_if.slave       bus
);

  localparam logic [1:0] ST_BOOT = BOOT;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_PEND = PEND;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_pc;
  logic             r_valid;
  logic             r_flush;
  logic             r_misalign;
  logic [WIDTH-1:0] r_bad_addr;
  pc_pend_t         r_pend;

  logic [WIDTH-1:0] w_next_pc;
  logic             w_flush;
  logic             w_misalign;
  logic [WIDTH-1:0] w_bad_addr;

  rv32i_pc_next_sel #(
    .WIDTH       (WIDTH),
    .TRAP_VECTOR (TRAP_VECTOR)
  ) u_next_sel (
    .i_pc              (r_pc),
    .i_trap            (bus.i_trap),
    .i_redirect        (bus.i_redirect),
    .i_redirect_target (bus.i_redirect_target),
    .i_pend            (r_pend),
    .o_next_pc         (w_next_pc),
    .o_flush           (w_flush),
    .o_misalign        (w_misalign),
    .o_bad_addr        (w_bad_addr)
  );

  // FSM, PC register and pending-redirect buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_BOOT;
      r_pc       <= RESET_VECTOR;
      r_valid    <= 1'b0;
      r_flush    <= 1'b0;
      r_misalign <= 1'b0;
      r_bad_addr <= '0;
      r_pend     <= '0;
    end else begin
      case (r_state)
        ST_BOOT: begin
          r_state    <= ST_RUN;
          r_valid    <= 1'b1;
          r_flush    <= 1'b0;
          r_misalign <= 1'b0;
          r_bad_addr <= '0;
        end
        ST_RUN, ST_PEND: begin
          if (!bus.i_stall) begin
            r_pc       <= w_next_pc;
            r_flush    <= w_flush;
            r_misalign <= w_misalign;
            r_bad_addr <= w_bad_addr;
            r_pend     <= '0;
            r_state    <= ST_RUN;
          end else begin
            r_flush    <= 1'b0;
            r_misalign <= 1'b0;
            r_bad_addr <= '0;
            // A buffered trap is sticky; only a newer trap may replace it.
            if (bus.i_trap) begin
              r_pend  <= '{valid: 1'b1, is_trap: 1'b1, target: '0};
              r_state <= ST_PEND;
            end else if (bus.i_redirect && !(r_pend.valid && r_pend.is_trap)) begin
              r_pend  <= '{valid: 1'b1, is_trap: 1'b0,
                           target: PC_MAX_W'(bus.i_redirect_target)};
              r_state <= ST_PEND;
            end else begin
              r_state <= r_state;
            end
          end
        end
        default: begin
          r_state <= ST_BOOT;
          r_pend  <= '0;
        end
      endcase
    end
  end

  assign bus.o_pc       = r_pc;
  assign bus.o_pc_plus4 = r_pc + WIDTH'(PC_INC);
  assign bus.o_valid    = r_valid;
  assign bus.o_flush    = r_flush;
`ifdef RV32I_PC_MISALIGN_EN
  assign bus.o_misalign = r_misalign;
  assign bus.o_bad_addr = r_bad_addr;
`else
  assign bus.o_misalign = 1'b0;
  assign bus.o_bad_addr = '0;
`endif

endmodule
